// File: rtl/execute_stage.sv
// Execute stage: ALU, condition-code register and the EX/MEM pipeline register.
// Handles stall, flush and CCR restore for interrupt return.
module execute_stage #(
  parameter int WIDTH = 16,
  parameter int RA    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [2:0]       operation,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [RA-1:0]    rd_in,
  input  logic             reg_write_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic             ccr_load,
  input  logic [2:0]       ccr_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] store_data,
  output logic [RA-1:0]    rd_out,
  output logic             reg_write_out,
  output logic             mem_read_out,
  output logic             mem_write_out,
  output logic [2:0]       ccr
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_NOT  = 3'b101,
    OP_PASS = 3'b110,
    OP_INC  = 3'b111
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             upd_c;
  logic             upd_nz;
  logic             commit;

  assign op     = op_e'(operation);
  assign commit = in_valid & ~stall & ~flush;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    upd_c   = 1'b0;
    upd_nz  = 1'b0;
    unique case (op)
      OP_NOP:  ;
      OP_ADD: begin
        {alu_c, alu_res} = {1'b0, src_a} + {1'b0, src_b};
        upd_c  = 1'b1;
        upd_nz = 1'b1;
      end
      OP_SUB: begin
        alu_res = src_a - src_b;
        alu_c   = (src_a < src_b);
        upd_c   = 1'b1;
        upd_nz  = 1'b1;
      end
      OP_AND: begin
        alu_res = src_a & src_b;
        upd_nz  = 1'b1;
      end
      OP_OR: begin
        alu_res = src_a | src_b;
        upd_nz  = 1'b1;
      end
      OP_NOT: begin
        alu_res = ~src_a;
        upd_nz  = 1'b1;
      end
      OP_PASS: alu_res = src_b;
      OP_INC: begin
        {alu_c, alu_res} = {1'b0, src_a} + {{WIDTH{1'b0}}, 1'b1};
        upd_c  = 1'b1;
        upd_nz = 1'b1;
      end
      default: ;
    endcase
  end

  // Flush beats stall; a bubble clears the control bits but leaves data as is.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      result        <= '0;
      store_data    <= '0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
    end else if (flush || (!stall && !in_valid)) begin
      out_valid     <= 1'b0;
      reg_write_out <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
    end else if (commit) begin
      out_valid     <= 1'b1;
      result        <= alu_res;
      store_data    <= src_b;
      rd_out        <= rd_in;
      reg_write_out <= reg_write_in;
      mem_read_out  <= mem_read_in;
      mem_write_out <= mem_write_in;
    end
  end

  // CCR is {C,N,Z}; a restore from ccr_in outranks any flag update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccr <= 3'b000;
    end else if (ccr_load) begin
      ccr <= ccr_in;
    end else if (commit && set_flags) begin
      if (upd_c)  ccr[2] <= alu_c;
      if (upd_nz) begin
        ccr[1] <= alu_res[WIDTH-1];
        ccr[0] <= (alu_res == '0);
      end
    end
  end

endmodule
